arb_requester: RTL and testbench



---
 rtl/arb_requester.sv | 208 ++++++++++++++++++++
 tb/tb_arb_requester.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_requester.sv
// arb_requester: queued job client for a 2-channel grant arbiter (ARB_REQUESTER_TIMEOUT_EN adds err_timeout).
// Latency: req rises one edge after a job is accepted while idle; backpressure: job_ready low while queue full.

module arb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module arb_requester #(
    parameter int LEN_W   = 4,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             job_valid,
    input  logic             job_ch,
    input  logic [LEN_W-1:0] job_len,
    output logic             job_ready,
    input  logic             gnt_0,
    input  logic             gnt_1,
    output logic             req_0,
    output logic             req_1,
    output logic             busy,
    output logic             done,
    output logic             done_ch
`ifdef ARB_REQUESTER_TIMEOUT_EN
    ,
    output logic             err_timeout
`endif
);
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
        $error("arb_requester: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
    end

    typedef struct packed {
        logic             ch;
        logic [LEN_W-1:0] len;
    } job_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_HOLD,
        ST_RELEASE
    } state_t;

    state_t           state;
    job_t             push_job;
    job_t             head_job;
    logic             q_full;
    logic             q_empty;
    logic             q_pop;
    logic             cur_ch;
    logic [LEN_W-1:0] cur_len;
    logic [LEN_W-1:0] cnt;
    logic             gnt_cur;

    assign push_job  = '{ch: job_ch, len: job_len};
    assign q_pop     = (state == ST_IDLE) && !q_empty;
    assign job_ready = !q_full;
    assign busy      = (state != ST_IDLE) || !q_empty;
    assign gnt_cur   = cur_ch ? gnt_1 : gnt_0;

    arb_fifo #(
        .WIDTH ($bits(job_t)),
        .DEPTH (DEPTH)
    ) u_job_q (
        .clock    (clock),
        .reset    (reset),
        .push     (job_valid),
        .push_dat (push_job),
        .pop      (q_pop),
        .pop_dat  (head_job),
        .full     (q_full),
        .empty    (q_empty)
    );

`ifdef ARB_REQUESTER_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    logic [WAIT_W-1:0] wait_cnt;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_IDLE;
            cur_ch  <= 1'b0;
            cur_len <= '0;
            cnt     <= '0;
            req_0   <= 1'b0;
            req_1   <= 1'b0;
            done    <= 1'b0;
            done_ch <= 1'b0;
`ifdef ARB_REQUESTER_TIMEOUT_EN
            err_timeout <= 1'b0;
            wait_cnt    <= '0;
`endif
        end else begin
            done <= 1'b0;
`ifdef ARB_REQUESTER_TIMEOUT_EN
            err_timeout <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (!q_empty) begin
                        cur_ch  <= head_job.ch;
                        cur_len <= head_job.len;
                        req_0   <= !head_job.ch;
                        req_1   <= head_job.ch;
`ifdef ARB_REQUESTER_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                        state   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // A grant on the limit cycle takes priority over the timeout.
                    if (gnt_cur) begin
                        cnt   <= cur_len;
                        state <= ST_HOLD;
                    end
`ifdef ARB_REQUESTER_TIMEOUT_EN
                    else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                        req_0       <= 1'b0;
                        req_1       <= 1'b0;
                        err_timeout <= 1'b1;
                        state       <= ST_RELEASE;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
`endif
                end
                ST_HOLD: begin
                    if (gnt_cur) begin
                        if (cnt == '0) begin
                            req_0   <= 1'b0;
                            req_1   <= 1'b0;
                            done    <= 1'b1;
                            done_ch <= cur_ch;
                            state   <= ST_RELEASE;
                        end else begin
                            cnt <= cnt - LEN_W'(1);
                        end
                    end
                end
                ST_RELEASE: begin
                    // Wait out the previous grant so it is not credited to the next job.
                    if (!gnt_cur) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_arb_requester.sv
// Bench for arb_requester: directed vector table, hand-written corner sequences, randomized run vs transaction model.
// Outputs sampled 1 time unit after each rising edge; inputs driven at the same point.
module tb_arb_requester;
    localparam int LEN_W   = 4;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 15;

    logic             clock = 1'b0;
    logic             reset;
    logic             job_valid;
    logic             job_ch;
    logic [LEN_W-1:0] job_len;
    logic             job_ready;
    logic             gnt_0;
    logic             gnt_1;
    logic             req_0;
    logic             req_1;
    logic             busy;
    logic             done;
    logic             done_ch;
`ifdef ARB_REQUESTER_TIMEOUT_EN
    logic             err_timeout;
`endif

    arb_requester #(
        .LEN_W   (LEN_W),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .job_valid (job_valid),
        .job_ch    (job_ch),
        .job_len   (job_len),
        .job_ready (job_ready),
        .gnt_0     (gnt_0),
        .gnt_1     (gnt_1),
        .req_0     (req_0),
        .req_1     (req_1),
        .busy      (busy),
        .done      (done),
        .done_ch   (done_ch)
`ifdef ARB_REQUESTER_TIMEOUT_EN
        ,
        .err_timeout (err_timeout)
`endif
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkn(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_job(input logic ch, input logic [LEN_W-1:0] len);
        job_valid = 1'b1;
        job_ch    = ch;
        job_len   = len;
        tick();
        job_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        job_valid = 1'b0; job_ch = 1'b0; job_len = '0; gnt_0 = 1'b0; gnt_1 = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    typedef struct {
        logic             vld;
        logic             ch;
        logic [LEN_W-1:0] len;
        logic             g0;
        logic             g1;
        logic             e_req0;
        logic             e_req1;
        logic             e_done;
        logic             e_done_ch;
        logic             e_ready;
        logic             e_busy;
    } vec_t;

    typedef struct packed {
        logic             ch;
        logic [LEN_W-1:0] len;
    } mjob_t;

    vec_t  tbl[11];
    mjob_t mq[$];

    initial begin
        // Single job {ch0,len2}; grant rises two cycles after req_0 and holds.
        tbl[0]  = '{1, 0, 4'd2, 0, 0,  0, 0, 0, 0, 1, 1};
        tbl[1]  = '{0, 0, 4'd0, 0, 0,  1, 0, 0, 0, 1, 1};
        tbl[2]  = '{0, 0, 4'd0, 0, 0,  1, 0, 0, 0, 1, 1};
        tbl[3]  = '{0, 0, 4'd0, 0, 0,  1, 0, 0, 0, 1, 1};
        tbl[4]  = '{0, 0, 4'd0, 1, 0,  1, 0, 0, 0, 1, 1};
        tbl[5]  = '{0, 0, 4'd0, 1, 0,  1, 0, 0, 0, 1, 1};
        tbl[6]  = '{0, 0, 4'd0, 1, 0,  1, 0, 0, 0, 1, 1};
        tbl[7]  = '{0, 0, 4'd0, 1, 0,  0, 0, 1, 0, 1, 1};
        tbl[8]  = '{0, 0, 4'd0, 1, 0,  0, 0, 0, 0, 1, 1};
        tbl[9]  = '{0, 0, 4'd0, 0, 0,  0, 0, 0, 0, 1, 0};
        tbl[10] = '{0, 0, 4'd0, 0, 0,  0, 0, 0, 0, 1, 0};

        do_reset();
        chk("rst_req0", req_0, 1'b0);
        chk("rst_req1", req_1, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_done_ch", done_ch, 1'b0);
        chk("rst_ready", job_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
`ifdef ARB_REQUESTER_TIMEOUT_EN
        chk("rst_err", err_timeout, 1'b0);
`endif

        for (int i = 0; i < 11; i++) begin
            job_valid = tbl[i].vld; job_ch = tbl[i].ch; job_len = tbl[i].len;
            gnt_0 = tbl[i].g0; gnt_1 = tbl[i].g1;
            tick();
            chk($sformatf("t1_req0[%0d]", i), req_0, tbl[i].e_req0);
            chk($sformatf("t1_req1[%0d]", i), req_1, tbl[i].e_req1);
            chk($sformatf("t1_done[%0d]", i), done, tbl[i].e_done);
            if (tbl[i].e_done) chk($sformatf("t1_done_ch[%0d]", i), done_ch, tbl[i].e_done_ch);
            chk($sformatf("t1_ready[%0d]", i), job_ready, tbl[i].e_ready);
            chk($sformatf("t1_busy[%0d]", i), busy, tbl[i].e_busy);
        end
        job_valid = 1'b0;

        // Back-to-back jobs with no grant: the first is popped, so the fifth fills the queue.
        gnt_0 = 1'b0; gnt_1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            job_valid = 1'b1; job_ch = i[0]; job_len = '0;
            tick();
            chk($sformatf("t2_ready[%0d]", i), job_ready, i < 4);
        end
        job_ch = 1'b1;
        tick();
        chk("t2_full_hold", job_ready, 1'b0);
        chk("t2_req0_wait", req_0, 1'b1);
        job_valid = 1'b0;
        begin
            int nd;
            int extra;
            nd = 0;
            extra = 0;
            for (int c = 0; c < 200 && nd < 5; c++) begin
                gnt_0 = req_0; gnt_1 = req_1;
                tick();
                if (done) begin
                    chk($sformatf("t2_order[%0d]", nd), done_ch, nd[0]);
                    nd++;
                end
            end
            chkn("t2_count", nd, 5);
            for (int c = 0; c < 20; c++) begin
                gnt_0 = req_0; gnt_1 = req_1;
                tick();
                if (done) extra++;
            end
            chkn("t2_extra_done", extra, 0);
            chk("t2_busy_end", busy, 1'b0);
        end

        // Grant on the wrong channel is ignored; the burst pauses when its grant drops.
        gnt_0 = 1'b1; gnt_1 = 1'b0;
        push_job(1'b1, 4'd3);
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("t3_req1_held[%0d]", i), req_1, 1'b1);
            chk($sformatf("t3_req0_low[%0d]", i), req_0, 1'b0);
            chk($sformatf("t3_no_done[%0d]", i), done, 1'b0);
        end
        gnt_0 = 1'b0;
        begin
            logic gseq [6];
            gseq = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
            for (int k = 0; k < 6; k++) begin
                gnt_1 = gseq[k];
                tick();
                chk($sformatf("t3_done[%0d]", k), done, k == 5);
                chk($sformatf("t3_req1[%0d]", k), req_1, k != 5);
            end
            chk("t3_done_ch", done_ch, 1'b1);
        end
        gnt_1 = 1'b0;
        tick();
        tick();

        // Reset while in HOLD with cnt=2 and a job queued behind it.
        push_job(1'b0, 4'd3);
        push_job(1'b1, 4'd1);
        gnt_0 = 1'b1;
        tick();
        tick();
        chk("t4_pre_req0", req_0, 1'b1);
        reset = 1'b1;
        tick();
        chk("t4_req0", req_0, 1'b0);
        chk("t4_req1", req_1, 1'b0);
        chk("t4_done", done, 1'b0);
        chk("t4_ready", job_ready, 1'b1);
        chk("t4_busy", busy, 1'b0);
        reset = 1'b0;
        gnt_0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("t4_idle_req[%0d]", i), req_0 | req_1, 1'b0);
            chk($sformatf("t4_idle_done[%0d]", i), done, 1'b0);
        end

        // Stale grant: the next same-channel job waits until gnt_0 clears.
        push_job(1'b0, 4'd0);
        push_job(1'b0, 4'd0);
        chk("t5_req0_up", req_0, 1'b1);
        gnt_0 = 1'b1;
        tick();
        tick();
        chk("t5_done", done, 1'b1);
        chk("t5_req0_drop", req_0, 1'b0);
        tick();
        chk("t5_stale1", req_0, 1'b0);
        tick();
        chk("t5_stale2", req_0, 1'b0);
        gnt_0 = 1'b0;
        tick();
        chk("t5_idle", req_0, 1'b0);
        tick();
        chk("t5_rerise", req_0, 1'b1);
        gnt_0 = 1'b1;
        tick();
        tick();
        chk("t5_done2", done, 1'b1);
        gnt_0 = 1'b0;
        tick();
        tick();
        chk("t5_busy_end", busy, 1'b0);

`ifdef ARB_REQUESTER_TIMEOUT_EN
        // No grant ever: error pulse TIMEOUT edges after REQ entry, then next job runs.
        push_job(1'b1, 4'd0);
        push_job(1'b0, 4'd0);
        chk("t6_req1_up", req_1, 1'b1);
        for (int k = 1; k <= TIMEOUT; k++) begin
            tick();
            chk($sformatf("t6_err[%0d]", k), err_timeout, k == TIMEOUT);
            chk($sformatf("t6_req1[%0d]", k), req_1, k != TIMEOUT);
            chk($sformatf("t6_done[%0d]", k), done, 1'b0);
        end
        tick();
        chk("t6_err_pulse", err_timeout, 1'b0);
        tick();
        chk("t6_next_req0", req_0, 1'b1);
        gnt_0 = 1'b1;
        tick();
        tick();
        chk("t6_next_done", done, 1'b1);
        chk("t6_next_done_ch", done_ch, 1'b0);
        gnt_0 = 1'b0;
        tick();
        tick();
`endif

        // Randomized traffic against a transaction-level model.
        do_reset();
        mq.delete();
        begin
            logic  active;
            mjob_t act;
            int    gcnt;
            int    ndone;
            logic  acc, pr0, pr1, pg0, pg1;
            mjob_t pj;
            active = 1'b0; gcnt = 0; ndone = 0; act = '0;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                job_valid = ($urandom_range(0, 9) < 4);
                job_ch    = 1'($urandom_range(0, 1));
                job_len   = LEN_W'($urandom_range(0, 5));
                gnt_0     = ($urandom_range(0, 9) < 6);
                gnt_1     = ($urandom_range(0, 9) < 6);
                acc = job_valid && job_ready;
                pj  = '{ch: job_ch, len: job_len};
                pr0 = req_0; pr1 = req_1; pg0 = gnt_0; pg1 = gnt_1;
                tick();
                if (active && ((!act.ch && pr0 && pg0) || (act.ch && pr1 && pg1))) gcnt++;
                if (acc) mq.push_back(pj);
                if (done) begin
                    chk("rnd_done_active", active, 1'b1);
                    if (active) begin
                        chk("rnd_done_ch", done_ch, act.ch);
                        chkn("rnd_granted_cycles", gcnt, int'(act.len) + 2);
                        ndone++;
                    end
                    active = 1'b0;
                end
`ifdef ARB_REQUESTER_TIMEOUT_EN
                if (err_timeout) begin
                    chk("rnd_err_active", active, 1'b1);
                    active = 1'b0;
                end
`endif
                if ((req_0 && !pr0) || (req_1 && !pr1)) begin
                    chk("rnd_rise_idle", active, 1'b0);
                    chkn("rnd_rise_has_job", int'(mq.size() > 0), 1);
                    if (mq.size() > 0) begin
                        act = mq.pop_front();
                        chk("rnd_rise_ch", req_1, act.ch);
                    end
                    active = 1'b1;
                    gcnt = 0;
                end
                chk("rnd_mutex", req_0 && req_1, 1'b0);
                chk("rnd_ready", job_ready, mq.size() < DEPTH);
                if (active) chk("rnd_req_held", act.ch ? req_1 : req_0, 1'b1);
                if (active || mq.size() > 0) chk("rnd_busy", busy, 1'b1);
            end
            chk("rnd_progress", ndone > 10, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
